if1_fetch_unit: RTL and testbench

//  Producer side of the IF1->ID pipeline register. Owns the fetch PC, issues
//  one-outstanding requests on the SRAM-like instruction bus, and presents
//  {PC, instruction, valid} to IF1_ID. Honours the hazard-unit stall and the

---
 rtl/if1_fetch_unit_pkg.sv | 24 ++
 rtl/if1_fetch_unit_if.sv | 47 ++++
 rtl/if1_fetch_unit.sv | 130 +++++++++++++
 tb/tb_if1_fetch_unit.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if1_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : if1_fetch_unit_pkg                                               |
// | Purpose : Shared widths, reset PC and FSM encoding for the IF1 fetch unit. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package if1_fetch_unit_pkg;

  localparam int WORD = 32;
  localparam logic [WORD-1:0] PC_RST = 32'h1C00_0000;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2
  } fetch_state_e;

  // Sequential fetch step; wraps modulo 2^WORD.
  function automatic logic [WORD-1:0] next_pc(input logic [WORD-1:0] pc);
    return pc + WORD'(4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/if1_fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : if1_fetch_unit_if                                                |
// | Purpose : Instruction-bus, hazard and IF1_ID signals of the fetch unit.    |
// |           FETCH_ADEF_EN adds the fetch_adef flag.                          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface if1_fetch_unit_if;
  import if1_fetch_unit_pkg::*;

  logic            stall;
  logic            redirect_valid;
  logic [WORD-1:0] redirect_pc;
  logic            inst_req;
  logic [WORD-1:0] inst_addr;
  logic            inst_addr_ok;
  logic            inst_data_ok;
  logic [WORD-1:0] inst_rdata;
  logic            fetch_valid;
  logic [WORD-1:0] fetch_pc;
  logic [WORD-1:0] fetch_inst;
`ifdef FETCH_ADEF_EN
  logic            fetch_adef;
`endif

  modport master (
`ifdef FETCH_ADEF_EN
    output fetch_adef,
`endif
    input  stall, redirect_valid, redirect_pc,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output inst_req, inst_addr,
    output fetch_valid, fetch_pc, fetch_inst
  );

  modport slave (
`ifdef FETCH_ADEF_EN
    input  fetch_adef,
`endif
    output stall, redirect_valid, redirect_pc,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  inst_req, inst_addr,
    input  fetch_valid, fetch_pc, fetch_inst
  );

endinterface
`default_nettype wire

// File: rtl/if1_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : if1_fetch_unit                                                   |
// | Purpose : IF1 producer: owns the fetch PC, one-outstanding instruction-bus |
// |           requests, stall hold and redirect cancel. Optional macro         |
// |           FETCH_ADEF_EN flags misaligned fetch PCs instead of requesting.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module if1_fetch_unit
  import if1_fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  if1_fetch_unit_if.master fif
);

  fetch_state_e    r_state;
  logic [WORD-1:0] r_pc;
  logic [WORD-1:0] r_buf;
  logic            r_cancel;

  logic w_misaligned;
  logic w_req;
  logic w_accept;

`ifdef FETCH_ADEF_EN
  assign w_misaligned = (r_state == IF_REQ) && (r_pc[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_req    = (r_state == IF_REQ) && !w_misaligned;
  assign w_accept = w_req && fif.inst_addr_ok;

  always_comb begin
    fif.inst_req    = !rst && w_req;
    fif.inst_addr   = r_pc;
    fif.fetch_pc    = rst ? PC_RST : r_pc;
    fif.fetch_valid = 1'b0;
    fif.fetch_inst  = '0;
`ifdef FETCH_ADEF_EN
    fif.fetch_adef  = 1'b0;
`endif
    // A redirect kills whatever would be presented this cycle.
    if (!rst && !fif.redirect_valid) begin
      case (r_state)
        IF_WAIT: begin
          if (fif.inst_data_ok && !r_cancel) begin
            fif.fetch_valid = 1'b1;
            fif.fetch_inst  = fif.inst_rdata;
          end
        end
        IF_HOLD: begin
          fif.fetch_valid = 1'b1;
          fif.fetch_inst  = r_buf;
        end
        default: begin
          if (w_misaligned) begin
            fif.fetch_valid = 1'b1;
`ifdef FETCH_ADEF_EN
            fif.fetch_adef  = 1'b1;
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IF_REQ;
      r_pc     <= PC_RST;
      r_cancel <= 1'b0;
      r_buf    <= '0;
    end else if (fif.redirect_valid) begin
      r_pc <= fif.redirect_pc;
      case (r_state)
        IF_REQ: begin
          // An address already accepted still returns data, which must be dropped.
          if (w_accept) begin
            r_cancel <= 1'b1;
            r_state  <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (fif.inst_data_ok) begin
            r_cancel <= 1'b0;
            r_state  <= IF_REQ;
          end else begin
            r_cancel <= 1'b1;
          end
        end
        default: r_state <= IF_REQ;
      endcase
    end else begin
      case (r_state)
        IF_REQ: begin
          if (w_misaligned) begin
            if (!fif.stall) r_pc <= next_pc(r_pc);
          end else if (w_accept) begin
            r_state <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (fif.inst_data_ok) begin
            if (r_cancel) begin
              r_cancel <= 1'b0;
              r_state  <= IF_REQ;
            end else if (!fif.stall) begin
              r_pc    <= next_pc(r_pc);
              r_state <= IF_REQ;
            end else begin
              r_buf   <= fif.inst_rdata;
              r_state <= IF_HOLD;
            end
          end
        end
        IF_HOLD: begin
          if (!fif.stall) begin
            r_pc    <= next_pc(r_pc);
            r_state <= IF_REQ;
          end
        end
        default: r_state <= IF_REQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if1_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_if1_fetch_unit                                                |
// | Purpose : Directed and randomized checks of if1_fetch_unit against an      |
// |           architectural-stream model (honours FETCH_ADEF_EN).              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_if1_fetch_unit;
  import if1_fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  if1_fetch_unit_if bus();

  if1_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .fif (bus)
  );

  always #5 clk = ~clk;

  // Memory image: odd multiplier keeps every address's word distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive_idle();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_addr_ok   = 1'b0;
    bus.inst_data_ok   = 1'b0;
    bus.inst_rdata     = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bus.inst_req !== 1'b0 || bus.fetch_valid !== 1'b0 ||
          bus.fetch_pc !== PC_RST || bus.fetch_inst !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs cyc %0d: req=%b valid=%b pc=%h inst=%h want 0 0 %h 0",
                 c, bus.inst_req, bus.fetch_valid, bus.fetch_pc, bus.fetch_inst, PC_RST);
      end
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h1C00_0000) begin
      bad++;
      $display("FAIL reset_first_req: req=%b addr=%h want 1 1c000000", bus.inst_req, bus.inst_addr);
    end
    step();
  endtask

  task automatic test_stream();
    logic [31:0] seen_pc[$];
    logic [31:0] seen_inst[$];
    bit          pend;
    logic [31:0] pa;
    do_reset();
    pend = 1'b0;
    pa   = '0;
    for (int c = 0; c < 8; c++) begin
      bus.inst_addr_ok = 1'b1;
      bus.inst_data_ok = pend;
      bus.inst_rdata   = pend ? mem_word(pa) : 32'h0;
      @(negedge clk);
      if (bus.fetch_valid === 1'b1) begin
        seen_pc.push_back(bus.fetch_pc);
        seen_inst.push_back(bus.fetch_inst);
      end
      pend = (bus.inst_req === 1'b1);
      pa   = bus.inst_addr;
      step();
    end
    drive_idle();
    total++;
    if (seen_pc.size() != 4) begin
      bad++;
      $display("FAIL stream_count: got %0d valid words want 4", seen_pc.size());
    end
    for (int i = 0; i < seen_pc.size(); i++) begin
      total++;
      if (seen_pc[i] !== PC_RST + 32'(4 * i) || seen_inst[i] !== mem_word(PC_RST + 32'(4 * i))) begin
        bad++;
        $display("FAIL stream_word %0d: pc=%h inst=%h want pc=%h inst=%h", i, seen_pc[i],
                 seen_inst[i], PC_RST + 32'(4 * i), mem_word(PC_RST + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.inst_addr_ok = 1'b1;
    step();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h0280_0421;
    bus.stall        = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (bus.fetch_valid !== 1'b1 || bus.fetch_inst !== 32'h0280_0421 ||
          bus.fetch_pc !== PC_RST || bus.inst_req !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cyc %0d: valid=%b inst=%h pc=%h req=%b want 1 02800421 %h 0",
                 c, bus.fetch_valid, bus.fetch_inst, bus.fetch_pc, bus.inst_req, PC_RST);
      end
      step();
      bus.inst_data_ok = 1'b0;
      bus.inst_addr_ok = 1'b1;
      bus.inst_rdata   = 32'hBAD0_BAD0;
      if (c == 3) bus.stall = 1'b0;
    end
    bus.inst_addr_ok = 1'b0;
    @(negedge clk);
    total++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== PC_RST + 32'd4 || bus.fetch_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: req=%b addr=%h valid=%b want 1 %h 0",
               bus.inst_req, bus.inst_addr, bus.fetch_valid, PC_RST + 32'd4);
    end
    step();
    drive_idle();
  endtask

  task automatic test_redirect_wait();
    do_reset();
    bus.inst_addr_ok = 1'b1;
    step();
    bus.inst_addr_ok   = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1C00_0100;
    @(negedge clk);
    total++;
    if (bus.fetch_valid !== 1'b0 || bus.inst_req !== 1'b0) begin
      bad++;
      $display("FAIL redir_wait_cycle: valid=%b req=%b want 0 0", bus.fetch_valid, bus.inst_req);
    end
    step();
    bus.redirect_valid = 1'b0;
    bus.inst_data_ok   = 1'b1;
    bus.inst_rdata     = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if (bus.fetch_valid !== 1'b0 || bus.inst_req !== 1'b0) begin
      bad++;
      $display("FAIL redir_stale_drop: valid=%b req=%b want 0 0", bus.fetch_valid, bus.inst_req);
    end
    step();
    bus.inst_data_ok = 1'b0;
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    total++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h1C00_0100) begin
      bad++;
      $display("FAIL redir_new_req: req=%b addr=%h want 1 1c000100", bus.inst_req, bus.inst_addr);
    end
    step();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h1234_5678;
    @(negedge clk);
    total++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h1C00_0100 || bus.fetch_inst !== 32'h1234_5678) begin
      bad++;
      $display("FAIL redir_new_word: valid=%b pc=%h inst=%h want 1 1c000100 12345678",
               bus.fetch_valid, bus.fetch_pc, bus.fetch_inst);
    end
    step();
    drive_idle();
  endtask

  task automatic test_redirect_data_stall();
    do_reset();
    bus.inst_addr_ok = 1'b1;
    step();
    bus.inst_addr_ok   = 1'b0;
    bus.inst_data_ok   = 1'b1;
    bus.inst_rdata     = 32'h1111_1111;
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1C00_0040;
    @(negedge clk);
    total++;
    if (bus.fetch_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_data_valid: valid=%b want 0", bus.fetch_valid);
    end
    step();
    bus.inst_data_ok   = 1'b0;
    bus.redirect_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bus.fetch_valid !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h1C00_0040) begin
        bad++;
        $display("FAIL redir_no_hold cyc %0d: valid=%b req=%b addr=%h want 0 1 1c000040",
                 c, bus.fetch_valid, bus.inst_req, bus.inst_addr);
      end
      step();
    end
    drive_idle();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    bus.inst_addr_ok   = 1'b1;
    @(negedge clk);
    total++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_req: req=%b addr=%h want 1 fffffffc", bus.inst_req, bus.inst_addr);
    end
    step();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hCAFE_0001;
    step();
    bus.inst_data_ok = 1'b0;
    @(negedge clk);
    total++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0000_0000) begin
      bad++;
      $display("FAIL wrap_next: req=%b addr=%h want 1 00000000", bus.inst_req, bus.inst_addr);
    end
    step();
    drive_idle();
  endtask

`ifdef FETCH_ADEF_EN
  task automatic test_adef();
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1C00_0102;
    step();
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b1;
    bus.inst_addr_ok   = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (bus.inst_req !== 1'b0 || bus.fetch_valid !== 1'b1 || bus.fetch_adef !== 1'b1 ||
          bus.fetch_inst !== 32'h0 || bus.fetch_pc !== 32'h1C00_0102) begin
        bad++;
        $display("FAIL adef_hold cyc %0d: req=%b valid=%b adef=%b inst=%h pc=%h want 0 1 1 0 1c000102",
                 c, bus.inst_req, bus.fetch_valid, bus.fetch_adef, bus.fetch_inst, bus.fetch_pc);
      end
      step();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1C00_0200;
    @(negedge clk);
    total++;
    if (bus.fetch_valid !== 1'b0) begin
      bad++;
      $display("FAIL adef_redirect: valid=%b want 0", bus.fetch_valid);
    end
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h1C00_0200 || bus.fetch_adef !== 1'b0) begin
      bad++;
      $display("FAIL adef_resume: req=%b addr=%h adef=%b want 1 1c000200 0",
               bus.inst_req, bus.inst_addr, bus.fetch_adef);
    end
    step();
    drive_idle();
  endtask
`endif

  // Model: the delivered stream must be exp_pc, exp_pc+4, ... restarted at each redirect.
  task automatic test_random(input int n);
    logic [31:0] exp_pc;
    logic [31:0] out_addr;
    bit          outstanding;
    bit          hold_exp;
    int          lat;
    int          delivered;
    do_reset();
    exp_pc      = PC_RST;
    out_addr    = '0;
    outstanding = 1'b0;
    hold_exp    = 1'b0;
    lat         = 0;
    delivered   = 0;
    for (int c = 0; c < n; c++) begin
      bus.inst_data_ok   = outstanding && (lat == 0);
      bus.inst_rdata     = bus.inst_data_ok ? mem_word(out_addr) : $urandom;
      bus.inst_addr_ok   = !outstanding && ($urandom_range(0, 2) != 0);
      bus.stall          = ($urandom_range(0, 3) == 0);
      bus.redirect_valid = ($urandom_range(0, 11) == 0);
      bus.redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                                       : PC_RST + 32'($urandom_range(0, 63)) * 32'd4;
      @(negedge clk);
      if (bus.inst_req === 1'b1) begin
        total++;
        if (outstanding || bus.inst_addr !== exp_pc) begin
          bad++;
          $display("FAIL rnd_req cyc %0d: addr=%h outstanding=%0d want addr %h with none outstanding",
                   c, bus.inst_addr, outstanding, exp_pc);
        end
      end
      if (bus.redirect_valid) begin
        total++;
        if (bus.fetch_valid !== 1'b0) begin
          bad++;
          $display("FAIL rnd_redirect_kill cyc %0d: valid=%b want 0", c, bus.fetch_valid);
        end
      end else begin
        if (hold_exp) begin
          total++;
          if (bus.fetch_valid !== 1'b1) begin
            bad++;
            $display("FAIL rnd_hold cyc %0d: valid=%b want 1", c, bus.fetch_valid);
          end
        end
        if (bus.fetch_valid === 1'b1) begin
          total++;
          if (bus.fetch_pc !== exp_pc || bus.fetch_inst !== mem_word(exp_pc)) begin
            bad++;
            $display("FAIL rnd_word cyc %0d: pc=%h inst=%h want pc=%h inst=%h",
                     c, bus.fetch_pc, bus.fetch_inst, exp_pc, mem_word(exp_pc));
          end
        end
      end
      hold_exp = !bus.redirect_valid && (bus.fetch_valid === 1'b1) && bus.stall;
      if (bus.redirect_valid) begin
        exp_pc = bus.redirect_pc;
      end else if (bus.fetch_valid === 1'b1 && !bus.stall) begin
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (bus.inst_data_ok) outstanding = 1'b0;
      else if (outstanding) lat--;
      if (bus.inst_req === 1'b1 && bus.inst_addr_ok) begin
        outstanding = 1'b1;
        out_addr    = bus.inst_addr;
        lat         = $urandom_range(0, 2);
      end
      step();
    end
    drive_idle();
    total++;
    if (delivered < n / 20) begin
      bad++;
      $display("FAIL rnd_progress: delivered=%0d want at least %0d", delivered, n / 20);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_data_stall();
    test_wrap();
`ifdef FETCH_ADEF_EN
    test_adef();
`endif
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
